alu_result_buffer: RTL
======================

Name: alu_result_buffer

Overview:
- Downstream stage of the 8-bit ALU. Captures each ALU result word and its flags (out, ovf, ERR, even, single) into a small synchronous FIFO with valid/ready handshakes on both sides.
- Keeps a saturating error counter and a sticky overflow flag for the testbench and the display logic.
- Decouples the combinational ALU from slower consumers.

Parameters:
- BITS, 8, width of the ALU result word.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- ERR_CNT_W, 8, width of the error counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_valid  input  1  upstream offers a result this cycle.
- o_ready  output  1  buffer can accept a result (not full).
- i_out  input  BITS  ALU result word.
- i_ovf  input  1  ALU overflow flag.
- i_ERR  input  1  ALU error flag.
- i_even  input  1  ALU even-zeros flag.
- i_single  input  1  ALU single-zero flag.
- o_valid  output  1  head entry available (not empty).
- i_ready  input  1  downstream accepts the head entry.
- o_out  output  BITS  head result word.
- o_ovf, o_ERR, o_even, o_single  output  1 each  head entry flags.
- o_count  output  $clog2(DEPTH)+1  number of stored entries.
- i_clr_stats  input  1  synchronous clear of the statistics.
- o_err_cnt  output  ERR_CNT_W  number of accepted entries with ERR=1, saturating.
- o_ovf_sticky  output  1  set by any accepted entry with ovf=1.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (i_clk, i_rst).
  - While i_rst=1: pointers=0, o_count=0, o_valid=0, o_ready=1, o_out=0, all head flags 0, o_err_cnt=0, o_ovf_sticky=0.
  - Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Storage word: {i_single, i_even, i_ERR, i_ovf, i_out}, BITS+4 bits wide.
- Push: i_valid && o_ready at a rising edge. The word is written at wr_ptr, and wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Pop: o_valid && i_ready at a rising edge. rd_ptr increments modulo DEPTH.
- Outputs: show-ahead. o_out and the head flags reflect mem[rd_ptr] combinationally whenever o_valid=1, and are forced to 0 when empty.
- Handshake flags:
  - o_ready = (o_count != DEPTH)
  - o_valid = (o_count != 0)
  - Both derive from registered state only; there is no combinational path from i_valid to o_valid or from i_ready to o_ready.
- Latency: a push into an empty buffer makes o_valid=1 one cycle later. There is no bypass.
- Counter update: o_count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full: o_ready=0, so i_valid is ignored and nothing is written. A pop in the same cycle frees a slot, but the push is not accepted until o_ready is re-evaluated the next cycle.
- Empty: i_ready is ignored and rd_ptr holds.
- Simultaneous push and pop when count is between 1 and DEPTH-1: both pointers advance and the count holds.
- Statistics update only on an accepted push.
  - o_err_cnt increments on i_ERR=1 and saturates at 2^ERR_CNT_W-1 (no wrap).
  - o_ovf_sticky is set on i_ovf=1.
- i_clr_stats=1 at an edge clears both statistics. If a push with ERR=1 or ovf=1 happens in the same cycle, the clear applies first and the push then counts: o_err_cnt=1 and/or o_ovf_sticky=1.
- i_clr_stats does not affect FIFO contents.

Optional Feature:
- Macro: ALU_BUF_DROP_ERR_EN.
- Defined: an accepted push with i_ERR=1 still updates o_err_cnt and o_ovf_sticky, but is not written to the FIFO. Pointers and o_count are unchanged, and o_ready follows the normal full rule.
- Undefined: ERR entries are stored like any other entry.

Test Plan:
- Reset then idle -> o_valid=0, o_ready=1, o_count=0, o_err_cnt=0, o_ovf_sticky=0. Asserting i_rst between clock edges clears a non-empty buffer at once.
- Push 0x11, 0x22, 0x33, 0x44 with i_ready=0 -> o_count=4, o_ready=0. A fifth push of 0x55 is ignored. Popping all four gives 0x11, 0x22, 0x33, 0x44 in order, then o_valid=0.
- Continuous push and pop for 10 words, 0x01..0x0A, over a buffer holding one entry -> o_count stays 1, pointers wrap past 3 -> 0, and the output order is preserved.
- Push 0xFF with ovf=1, then 0x00 with ERR=1 three times -> o_ovf_sticky=1, o_err_cnt=3. Asserting i_clr_stats together with an ERR push -> o_err_cnt=1.
- 300 pushes with ERR=1 (with concurrent pops) -> o_err_cnt saturates at 255.
- With ALU_BUF_DROP_ERR_EN defined: push 0x10 (ERR=0), 0x20 (ERR=1), 0x30 (ERR=0) -> o_count=2, outputs 0x10 then 0x30, o_err_cnt=1.

Source files
------------

// File: rtl/alu_result_buffer.sv
// Show-ahead result FIFO behind the 8-bit ALU, with a saturating error counter and a sticky overflow flag.
// Optional build macro ALU_BUF_DROP_ERR_EN: ERR results are counted but not stored.
module alu_result_buffer #(
    parameter int BITS      = 8,
    parameter int DEPTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    // upstream (ALU) side
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [BITS-1:0]            i_out,
    input  logic                       i_ovf,
    input  logic                       i_ERR,
    input  logic                       i_even,
    input  logic                       i_single,
    // downstream side
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [BITS-1:0]            o_out,
    output logic                       o_ovf,
    output logic                       o_ERR,
    output logic                       o_even,
    output logic                       o_single,
    output logic [$clog2(DEPTH):0]     o_count,
    // statistics
    input  logic                       i_clr_stats,
    output logic [ERR_CNT_W-1:0]       o_err_cnt,
    output logic                       o_ovf_sticky
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = BITS + 4;

    logic [WORD_W-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_ovf_sticky;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_store;
    logic                 w_err_sat;
    logic [WORD_W-1:0]    w_head;

    // Handshake flags come from the registered count only, so no input-to-output combinational path.
    assign o_ready = (r_count != CNT_W'(DEPTH));
    assign o_valid = (r_count != '0);

    assign w_push = i_valid && o_ready;
    assign w_pop  = o_valid && i_ready;

`ifdef ALU_BUF_DROP_ERR_EN
    assign w_store = w_push && !i_ERR;
`else
    assign w_store = w_push;
`endif

    // NOTE: the storage array is deliberately not reset; the head is masked to zero while empty,
    // so stale contents are never visible and the array can map onto plain RAM/flops without reset.
    always_ff @(posedge i_clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= {i_single, i_even, i_ERR, i_ovf, i_out};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear takes effect first, then a same-cycle accepted push is still counted.
    assign w_err_sat = &r_err_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_cnt    <= '0;
            r_ovf_sticky <= 1'b0;
        end else if (i_clr_stats) begin
            r_err_cnt    <= (w_push && i_ERR) ? ERR_CNT_W'(1) : '0;
            r_ovf_sticky <= w_push && i_ovf;
        end else if (w_push) begin
            if (i_ERR && !w_err_sat) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
            if (i_ovf) begin
                r_ovf_sticky <= 1'b1;
            end
        end
    end

    assign w_head = o_valid ? r_mem[r_rd_ptr] : '0;

    assign {o_single, o_even, o_ERR, o_ovf, o_out} = w_head;
    assign o_count      = r_count;
    assign o_err_cnt    = r_err_cnt;
    assign o_ovf_sticky = r_ovf_sticky;

endmodule
